// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into 32-bit words,
// writes them to consecutive word addresses and holds the CPU in reset meanwhile.
module imem_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset_out,
    output logic              busy,
    output logic              done,
    output logic [31:0]       checksum
);

    localparam int unsigned BCNT_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        FINISH
    } state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0] count_q, count_n;
    logic [ADDR_W-1:0] index_q, index_n;
    logic [BCNT_W-1:0] bcnt_q, bcnt_n;
    logic [31:0]       shift_q, shift_n;
    logic              byte_ready_n;
    logic              imem_we_n;
    logic [ADDR_W-1:0] imem_addr_n;
    logic [31:0]       imem_wdata_n;
    logic              cpu_reset_n;
    logic              busy_n;
    logic              done_n;
    logic [31:0]       checksum_n;

    // Next-state and next-output logic; every output is a flop fed from here.
    always_comb begin
        state_n      = state;
        count_n      = count_q;
        index_n      = index_q;
        bcnt_n       = bcnt_q;
        shift_n      = shift_q;
        imem_addr_n  = imem_addr;
        imem_wdata_n = imem_wdata;
        cpu_reset_n  = cpu_reset_out;
        checksum_n   = checksum;

        case (state)
            IDLE: begin
                if (start) begin
                    cpu_reset_n = 1'b1;
                    checksum_n  = '0;
                    index_n     = '0;
                    bcnt_n      = '0;
                    count_n     = word_count;
                    state_n     = (word_count == '0) ? FINISH : COLLECT;
                end
            end
            COLLECT: begin
                if (byte_valid) begin
                    shift_n = {shift_q[23:0], byte_in};
                    bcnt_n  = bcnt_q + BCNT_W'(1);
                    // Fourth byte completes the word: stage it for the write cycle.
                    if (bcnt_q == BCNT_W'(3)) begin
                        imem_wdata_n = {shift_q[23:0], byte_in};
                        imem_addr_n  = ADDR_W'(BASE_ADDR) + index_q;
                        state_n      = WRITE;
                    end
                end
            end
            WRITE: begin
                checksum_n = checksum + imem_wdata;
                if (index_q == count_q - ADDR_W'(1)) begin
                    state_n = FINISH;
                end else begin
                    index_n = index_q + ADDR_W'(1);
                    state_n = COLLECT;
                end
            end
            FINISH: begin
                cpu_reset_n = 1'b0;
                state_n     = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        byte_ready_n = (state_n == COLLECT);
        imem_we_n    = (state_n == WRITE);
        busy_n       = (state_n != IDLE);
        done_n       = (state_n == FINISH);
    end

    // State and output registers; reset aborts any load in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            count_q       <= '0;
            index_q       <= '0;
            bcnt_q        <= '0;
            shift_q       <= '0;
            byte_ready    <= 1'b0;
            imem_we       <= 1'b0;
            imem_addr     <= '0;
            imem_wdata    <= '0;
            cpu_reset_out <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            checksum      <= '0;
        end else begin
            state         <= state_n;
            count_q       <= count_n;
            index_q       <= index_n;
            bcnt_q        <= bcnt_n;
            shift_q       <= shift_n;
            byte_ready    <= byte_ready_n;
            imem_we       <= imem_we_n;
            imem_addr     <= imem_addr_n;
            imem_wdata    <= imem_wdata_n;
            cpu_reset_out <= cpu_reset_n;
            busy          <= busy_n;
            done          <= done_n;
            checksum      <= checksum_n;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (default and ADDR_W=4/BASE_ADDR=14) share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_imem_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic [9:0] word_count;
    logic [3:0] word_count1;
    logic [7:0] byte_in;
    logic       byte_valid;

    logic       br0, we0, cpu0, busy0, done0;
    logic [9:0] a0;
    logic [31:0] d0, cs0;
    logic       br1, we1, cpu1, busy1, done1;
    logic [3:0] a1;
    logic [31:0] d1, cs1;

    assign word_count1 = word_count[3:0];

    imem_loader u_dut0 (
        .clk(clk), .reset(reset), .start(start), .word_count(word_count),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(br0),
        .imem_we(we0), .imem_addr(a0), .imem_wdata(d0), .cpu_reset_out(cpu0),
        .busy(busy0), .done(done0), .checksum(cs0)
    );

    imem_loader #(.ADDR_W(4), .BASE_ADDR(14)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .word_count(word_count1),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(br1),
        .imem_we(we1), .imem_addr(a1), .imem_wdata(d1), .cpu_reset_out(cpu1),
        .busy(busy1), .done(done1), .checksum(cs1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Model state per instance
    int          aw_of[2]   = '{10, 4};
    int          base_of[2] = '{0, 14};
    bit          e_ready[2], e_we[2], e_done[2], e_busy[2], e_cpu[2];
    int          e_addr[2];
    logic [31:0] e_wdata[2], e_sum[2], m_acc[2];
    int          m_count[2], m_idx[2], m_nb[2];
    bit          m_took[2];
    int          last_cyc[2];

    logic [31:0] wa0[$], wd0[$], wa1[$];
    int          done_cyc0;

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] cyc=%0d got=%h want=%h", name, inst, cyc, act, exp);
        end
    endtask

    // Predicts the outputs seen after this edge from the inputs presented before it.
    task automatic model_update(input int i);
        int wc;
        bit o_ready, o_we, o_done, o_busy;
        bit n_ready, n_we, n_done;
        wc = (i == 0) ? int'(word_count) : int'(word_count[3:0]);
        m_took[i] = 1'b0;
        if (reset) begin
            e_ready[i] = 0; e_we[i] = 0; e_done[i] = 0; e_busy[i] = 0; e_cpu[i] = 1;
            e_addr[i] = 0; e_wdata[i] = '0; e_sum[i] = '0; m_acc[i] = '0;
            m_count[i] = 0; m_idx[i] = 0; m_nb[i] = 0;
            return;
        end
        o_ready = e_ready[i]; o_we = e_we[i]; o_done = e_done[i]; o_busy = e_busy[i];
        n_ready = o_ready; n_we = 0; n_done = 0;
        if (o_done) begin
            e_busy[i] = 0;
            e_cpu[i]  = 0;
        end else if (!o_busy && start) begin
            e_busy[i] = 1;
            e_cpu[i]  = 1;
            e_sum[i]  = '0;
            if (wc == 0) begin
                n_done = 1;
            end else begin
                m_count[i] = wc; m_idx[i] = 0; m_nb[i] = 0; n_ready = 1;
            end
        end
        if (o_we) begin
            e_sum[i] = e_sum[i] + e_wdata[i];
            if (m_idx[i] == m_count[i] - 1) n_done = 1;
            else begin
                m_idx[i]++;
                n_ready = 1;
            end
        end
        if (o_ready && byte_valid) begin
            m_took[i] = 1'b1;
            m_acc[i]  = {m_acc[i][23:0], byte_in};
            m_nb[i]++;
            if (m_nb[i] == 4) begin
                m_nb[i]    = 0;
                n_we       = 1;
                n_ready    = 0;
                e_wdata[i] = m_acc[i];
                e_addr[i]  = (base_of[i] + m_idx[i]) % (1 << aw_of[i]);
                if (m_idx[i] == m_count[i] - 1) last_cyc[i] = cyc - 1;
            end
        end
        e_ready[i] = n_ready; e_we[i] = n_we; e_done[i] = n_done;
    endtask

    task automatic cmp_inst(input int i, input logic br, input logic we,
                            input logic [31:0] a, input logic [31:0] d, input logic cpu,
                            input logic bsy, input logic dn, input logic [31:0] cs);
        chk("byte_ready", i, 32'(br), 32'(e_ready[i]));
        chk("imem_we", i, 32'(we), 32'(e_we[i]));
        chk("done", i, 32'(dn), 32'(e_done[i]));
        chk("busy", i, 32'(bsy), 32'(e_busy[i]));
        chk("cpu_reset_out", i, 32'(cpu), 32'(e_cpu[i]));
        chk("checksum", i, cs, e_sum[i]);
        if (e_we[i]) begin
            chk("imem_addr", i, a, 32'(e_addr[i]));
            chk("imem_wdata", i, d, e_wdata[i]);
        end
    endtask

    // Per-cycle compare and write/done logging, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst(0, br0, we0, 32'(a0), d0, cpu0, busy0, done0, cs0);
            cmp_inst(1, br1, we1, 32'(a1), d1, cpu1, busy1, done1, cs1);
            if (we0 === 1'b1) begin
                wa0.push_back(32'(a0));
                wd0.push_back(d0);
            end
            if (we1 === 1'b1) wa1.push_back(32'(a1));
            if (done0 === 1'b1) done_cyc0 = cyc;
        end
    end

    task automatic step(input bit r, input bit s, input logic [9:0] wc, input bit v,
                        input logic [7:0] b);
        reset = r; start = s; word_count = wc; byte_valid = v; byte_in = b;
        @(posedge clk);
        cyc++;
        model_update(0);
        model_update(1);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int tries;
        for (int g = 0; g < gap; g++) step(0, 0, '0, 0, 8'($urandom));
        tries = 0;
        do begin
            step(0, 0, '0, 1, b);
            tries++;
        end while (!m_took[0] && tries < 16);
        if (!m_took[0]) begin
            bad++;
            $display("FAIL byte_accept_timeout cyc=%0d got=none want=accept", cyc);
        end
        total++;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (e_busy[0] && t < 20) begin
            step(0, 0, '0, 0, 8'h00);
            t++;
        end
        total++;
        if (e_busy[0]) begin
            bad++;
            $display("FAIL idle_timeout cyc=%0d got=busy want=idle", cyc);
        end
        step(0, 0, '0, 0, 8'h00);
    endtask

    task automatic clear_logs();
        wa0.delete(); wd0.delete(); wa1.delete();
        done_cyc0 = -1;
    endtask

    logic [7:0] c1_bytes[8] = '{8'h20, 8'h08, 8'h00, 8'h01, 8'h20, 8'h09, 8'h00, 8'h01};

    initial begin
        int start_cyc, wc, gap, rst_at;
        bit rst_inj;
        reset = 1; start = 0; word_count = '0; byte_valid = 0; byte_in = '0;
        clear_logs();
        for (int k = 0; k < 3; k++) step(1, 0, '0, 0, 8'h00);
        chk_en = 1'b1;

        // Reset values pinned literally
        chk("rst_byte_ready", 0, 32'(br0), 32'd0);
        chk("rst_imem_we", 0, 32'(we0), 32'd0);
        chk("rst_imem_addr", 0, 32'(a0), 32'd0);
        chk("rst_imem_wdata", 0, d0, 32'd0);
        chk("rst_busy", 0, 32'(busy0), 32'd0);
        chk("rst_done", 0, 32'(done0), 32'd0);
        chk("rst_checksum", 0, cs0, 32'd0);
        chk("rst_cpu_reset", 0, 32'(cpu0), 32'd1);

        // Case 1 and 2: two words, back-to-back and with 3-cycle gaps
        for (int g = 0; g <= 3; g += 3) begin
            clear_logs();
            step(0, 1, 10'd2, 0, 8'h00);
            for (int k = 0; k < 8; k++) send(c1_bytes[k], g);
            wait_idle();
            chk("c12_nwrites", g, 32'(wa0.size()), 32'd2);
            chk("c12_addr0", g, wa0[0], 32'd0);
            chk("c12_data0", g, wd0[0], 32'h2008_0001);
            chk("c12_addr1", g, wa0[1], 32'd1);
            chk("c12_data1", g, wd0[1], 32'h2009_0001);
            chk("c12_checksum", g, cs0, 32'h4011_0002);
            chk("c12_done_latency", g, 32'(done_cyc0 - last_cyc[0]), 32'd2);
            chk("c12_cpu_released", g, 32'(cpu0), 32'd0);
            chk("c12_base14_addr0", g, wa1[0], 32'd14);
            chk("c12_base14_addr1", g, wa1[1], 32'd15);
        end

        // Case 3: zero-length load
        clear_logs();
        start_cyc = cyc;
        step(0, 1, 10'd0, 0, 8'h00);
        chk("c3_done_now", 0, 32'(done0), 32'd1);
        chk("c3_cpu_held", 0, 32'(cpu0), 32'd1);
        wait_idle();
        chk("c3_done_cycle", 0, 32'(done_cyc0), 32'(start_cyc + 1));
        chk("c3_nwrites", 0, 32'(wa0.size()), 32'd0);
        chk("c3_cpu_released", 0, 32'(cpu0), 32'd0);

        // Case 4: start re-asserted during word 2 is ignored
        clear_logs();
        step(0, 1, 10'd3, 0, 8'h00);
        for (int k = 0; k < 12; k++) begin
            if (k == 6) step(0, 1, 10'd5, 0, 8'h00);
            send((k % 4 == 3) ? 8'(k / 4 + 1) : 8'h00, 0);
        end
        wait_idle();
        chk("c4_nwrites", 0, 32'(wa0.size()), 32'd3);
        chk("c4_checksum", 0, cs0, 32'd6);
        chk("c4_data2", 0, wd0[2], 32'd3);

        // Case 5: reset mid-word aborts, then a fresh load
        clear_logs();
        step(0, 1, 10'd2, 0, 8'h00);
        send(8'hAA, 0);
        send(8'hBB, 0);
        step(1, 0, '0, 1, 8'hCC);
        step(0, 0, '0, 0, 8'h00);
        chk("c5_nwrites", 0, 32'(wa0.size()), 32'd0);
        chk("c5_cpu_held", 0, 32'(cpu0), 32'd1);
        chk("c5_busy", 0, 32'(busy0), 32'd0);
        step(0, 1, 10'd1, 0, 8'h00);
        send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 1);
        wait_idle();
        chk("c5_addr", 0, wa0[0], 32'd0);
        chk("c5_data", 0, wd0[0], 32'hDEAD_BEEF);
        chk("c5_base14_addr", 1, wa1[0], 32'd14);
        chk("c5_checksum", 0, cs0, 32'hDEAD_BEEF);

        // Case 6: address wrap in the 4-bit instance
        clear_logs();
        step(0, 1, 10'd3, 0, 8'h00);
        for (int k = 0; k < 12; k++) send(8'($urandom), 0);
        wait_idle();
        chk("c6_nwrites", 1, 32'(wa1.size()), 32'd3);
        chk("c6_addr0", 1, wa1[0], 32'd14);
        chk("c6_addr1", 1, wa1[1], 32'd15);
        chk("c6_addr2", 1, wa1[2], 32'd0);
        chk("c6_wide_addr2", 0, wa0[2], 32'd2);

        // Randomized loads with gaps, stray starts and occasional aborts
        for (int n = 0; n < 40; n++) begin
            wc      = int'($urandom_range(0, 6));
            gap     = int'($urandom_range(0, 2));
            rst_inj = ($urandom_range(0, 99) < 10);
            rst_at  = int'($urandom_range(0, 4 * wc));
            step(0, 1, 10'(wc), 0, 8'h00);
            for (int k = 0; k < 4 * wc; k++) begin
                if (rst_inj && k == rst_at) begin
                    step(1, 0, '0, 1, 8'($urandom));
                    break;
                end
                if ($urandom_range(0, 9) == 0) step(0, 1, 10'($urandom_range(0, 15)), 0, 8'h00);
                send(8'($urandom), int'($urandom_range(0, gap)));
            end
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
